alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_muldiv_iter.sv | 107 ++++++++++
 rtl/alu_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and decode constants for the execute-stage ALU and its
// iterative multiply/divide datapath.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // M-extension ops occupy the upper half of the code space.
  function automatic logic is_muldiv(input alu_op_e op);
    return op[4];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiplier (shift-add) and restoring divider on operand
// magnitudes; one iteration per clock, XLEN iterations per operation.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic                 busy_p1;
  logic [CNT_W-1:0]     cnt_p1;
  logic                 is_div_p1;
  logic                 hi_sel_p1;
  logic                 neg_p_p1;
  logic                 neg_r_p1;
  logic [XLEN-1:0]      opnd_p1;
  logic [2*XLEN-1:0]    work_p1;
  logic [2*XLEN-1:0]    work_nxt;
  logic                 sa;
  logic                 sb;
  logic [XLEN:0]        mul_sum;
  logic [XLEN:0]        div_tmp;
  logic [XLEN:0]        div_diff;
  logic                 div_ge;
  logic [2*XLEN-1:0]    prod;
  logic [XLEN-1:0]      quot;
  logic [XLEN-1:0]      rmd;

  // Divide: signed unless fn[0]. Multiply: MULHU unsigned both, MULHSU unsigned b.
  always_comb begin
    sa = a[XLEN-1] & (fn[2] ? ~fn[0] : ~(fn[1] & fn[0]));
    sb = b[XLEN-1] & (fn[2] ? ~fn[0] : ~fn[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1 <= 1'b0;
      cnt_p1  <= '0;
    end else if (start) begin
      busy_p1 <= 1'b1;
      cnt_p1  <= '0;
    end else if (busy_p1) begin
      if (cnt_p1 == CNT_LAST) busy_p1 <= 1'b0;
      cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // work holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_ff @(posedge clk) begin
    if (start) begin
      work_p1   <= {{XLEN{1'b0}}, neg_if(a, sa)};
      opnd_p1   <= neg_if(b, sb);
      is_div_p1 <= fn[2];
      hi_sel_p1 <= fn[2] ? fn[1] : (fn[1:0] != 2'b00);
      neg_p_p1  <= sa ^ sb;
      neg_r_p1  <= sa;
    end else if (busy_p1) begin
      work_p1 <= work_nxt;
    end
  end

  always_comb begin
    mul_sum  = {1'b0, work_p1[2*XLEN-1:XLEN]} + {1'b0, opnd_p1};
    div_tmp  = work_p1[2*XLEN-1:XLEN-1];
    div_diff = div_tmp - {1'b0, opnd_p1};
    div_ge   = (div_tmp >= {1'b0, opnd_p1});
    if (is_div_p1)
      work_nxt = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]), work_p1[XLEN-2:0], div_ge};
    else if (work_p1[0])
      work_nxt = {mul_sum, work_p1[XLEN-1:1]};
    else
      work_nxt = {1'b0, work_p1[2*XLEN-1:1]};
  end

  // The final iteration's value is signed-corrected combinationally so the
  // top can register it on the same edge that completes the operation.
  always_comb begin
    prod = neg_wide_if(work_nxt, neg_p_p1);
    quot = neg_if(work_nxt[XLEN-1:0], neg_p_p1);
    rmd  = neg_if(work_nxt[2*XLEN-1:XLEN], neg_r_p1);
    if (is_div_p1)
      result = hi_sel_p1 ? rmd : quot;
    else
      result = hi_sel_p1 ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    done = busy_p1 & (cnt_p1 == CNT_LAST);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes ALUOp/funct3/funct7 (with optional RV32M), runs
// base ops in one registered cycle and MUL/DIV/REM on an iterative datapath.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter bit M_EXT   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e                  state;
  state_e                  state_nxt;
  alu_op_e                 op_dec;
  logic                    accept;
  logic signed [XLEN-1:0]  a_s;
  logic signed [XLEN-1:0]  b_s;
  logic [SHAMT_W-1:0]      shamt;
  logic [XLEN-1:0]         alu_res;
  logic [XLEN-1:0]         spec_res;
  logic [XLEN-1:0]         res_nxt;
  logic [XLEN-1:0]         mdu_res;
  logic                    is_m;
  logic                    is_div;
  logic                    div_by_zero;
  logic                    div_ovf;
  logic                    special;
  logic                    fin;
  logic                    mdu_start;
  logic                    mdu_done;

  assign a_s      = a;
  assign b_s      = b;
  assign shamt    = b[SHAMT_W-1:0];
  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    op_dec = OP_ADD;
    case (alu_op)
      ALUOP_ADD: op_dec = OP_ADD;
      ALUOP_SUB: op_dec = OP_SUB;
      default: begin
        if (M_EXT && alu_op == ALUOP_RTYPE && funct7 == FUNCT7_MULDIV) begin
          op_dec = alu_op_e'({2'b10, funct3});
        end else begin
          case (funct3)
            3'b000:  op_dec = (alu_op == ALUOP_RTYPE && funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  op_dec = OP_SLL;
            3'b010:  op_dec = OP_SLT;
            3'b011:  op_dec = OP_SLTU;
            3'b100:  op_dec = OP_XOR;
            3'b101:  op_dec = (funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  op_dec = OP_OR;
            default: op_dec = OP_AND;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    case (op_dec)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = a_s >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow bypass the iterative divider entirely.
  always_comb begin
    is_m        = is_muldiv(op_dec);
    is_div      = is_m & op_dec[2];
    div_by_zero = (b == '0);
    div_ovf     = ~funct3[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    special     = is_div & (div_by_zero | div_ovf);
    if (div_by_zero)
      spec_res = funct3[1] ? a : '1;
    else
      spec_res = funct3[1] ? '0 : a;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    res_nxt   = alu_res;
    mdu_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_m) begin
            fin = 1'b1;
          end else if (special) begin
            fin     = 1'b1;
            res_nxt = spec_res;
          end else begin
            mdu_start = 1'b1;
            state_nxt = is_div ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (mdu_done) begin
          fin       = 1'b1;
          res_nxt   = mdu_res;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Output stage: result/zero hold until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else begin
      out_valid <= fin;
      if (fin) begin
        result <= res_nxt;
        zero   <= (res_nxt == '0);
      end
    end
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .fn     (funct3),
    .a      (a),
    .b      (b),
    .done   (mdu_done),
    .result (mdu_res)
  );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, base ops, back-to-back issue,
// iterative MUL/DIV latency, special cases and mid-operation reset.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .M_EXT(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] va, input logic [31:0] vb);
    alu_op = op;
    funct3 = f3;
    funct7 = f7;
    a      = va;
    b      = vb;
  endtask

  // Issue one op and wait for out_valid; lat counts edges from the accept edge.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] va, input logic [31:0] vb,
                        output int lat, output bit busy_ready);
    set_op(op, f3, f7, va, vb);
    in_valid = 1'b1;
    tick();
    in_valid   = 1'b0;
    lat        = 1;
    busy_ready = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_ready = 1'b1;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit busy_ready;
    bit seen;

    rst      = 1'b1;
    in_valid = 1'b1;
    set_op(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    tick(); tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);

    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    tick();
    chk("first_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("first_accept_result", result, 32'd2);

    set_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7);
    tick();
    chk("b2b_sub_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_sub_result", result, 32'hFFFF_FFFE);
    chk("b2b_sub_zero", {31'd0, zero}, 32'd0);
    set_op(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'h0000_0024);
    tick();
    chk("b2b_sra_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_sra_result", result, 32'hF800_0000);
    in_valid = 1'b0;
    tick();
    chk("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("b2b_result_hold", result, 32'hF800_0000);

    run_op(2'b11, 3'b000, 7'h20, 32'd10, 32'd3, lat, busy_ready);
    chk("addi_result", result, 32'd13);
    chk("addi_lat", lat, 32'd1);
    run_op(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, lat, busy_ready);
    chk("slt_result", result, 32'd1);
    run_op(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, lat, busy_ready);
    chk("sltu_result", result, 32'd0);
    chk("sltu_zero", {31'd0, zero}, 32'd1);
    run_op(2'b11, 3'b001, 7'h00, 32'd3, 32'h0000_0021, lat, busy_ready);
    chk("slli_result", result, 32'd6);
    run_op(2'b10, 3'b100, 7'h00, 32'h0000_F0F0, 32'h0000_FF00, lat, busy_ready);
    chk("xor_result", result, 32'h0000_0FF0);
    run_op(2'b01, 3'b111, 7'h00, 32'd3, 32'd3, lat, busy_ready);
    chk("aluop_sub_result", result, 32'd0);
    chk("aluop_sub_zero", {31'd0, zero}, 32'd1);

    run_op(2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'd2, lat, busy_ready);
    chk("mulh_result", result, 32'hFFFF_FFFF);
    chk("mulh_lat", lat, 32'd33);
    chk("mulh_busy_ready", {31'd0, busy_ready}, 32'd0);
    chk("mulh_ready_at_done", {31'd0, in_ready}, 32'd1);
    run_op(2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'd2, lat, busy_ready);
    chk("mulhu_result", result, 32'd1);
    chk("mulhu_lat", lat, 32'd33);
    run_op(2'b10, 3'b000, 7'h01, 32'd7, 32'hFFFF_FFFD, lat, busy_ready);
    chk("mul_result", result, 32'hFFFF_FFEB);

    set_op(2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2);
    in_valid = 1'b1;
    tick();
    set_op(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
    lat  = 1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      lat++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) seen = 1'b1;
    end
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) seen = 1'b1;
      tick();
      lat++;
    end
    chk("div_busy_ignored", {31'd0, seen}, 32'd0);
    chk("div_lat", lat, 32'd33);
    chk("div_result", result, 32'hFFFF_FFFD);
    tick();
    chk("div_nothing_queued", {31'd0, out_valid}, 32'd0);

    run_op(2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2, lat, busy_ready);
    chk("rem_result", result, 32'hFFFF_FFFF);
    chk("rem_lat", lat, 32'd33);
    run_op(2'b10, 3'b101, 7'h01, 32'd100, 32'd7, lat, busy_ready);
    chk("divu_result", result, 32'd14);
    run_op(2'b10, 3'b111, 7'h01, 32'd100, 32'd7, lat, busy_ready);
    chk("remu_result", result, 32'd2);

    run_op(2'b10, 3'b101, 7'h01, 32'd9, 32'd0, lat, busy_ready);
    chk("divu_by0_result", result, 32'hFFFF_FFFF);
    chk("divu_by0_lat", lat, 32'd1);
    run_op(2'b10, 3'b111, 7'h01, 32'd9, 32'd0, lat, busy_ready);
    chk("remu_by0_result", result, 32'd9);
    run_op(2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ready);
    chk("rem_ovf_result", result, 32'd0);
    chk("rem_ovf_lat", lat, 32'd1);
    chk("rem_ovf_zero", {31'd0, zero}, 32'd1);
    run_op(2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_ready);
    chk("div_ovf_result", result, 32'h8000_0000);

    set_op(2'b10, 3'b100, 7'h01, 32'd100, 32'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_valid", {31'd0, seen}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    run_op(2'b00, 3'b000, 7'h00, 32'd1, 32'd1, lat, busy_ready);
    chk("post_rst_add_result", result, 32'd2);
    chk("post_rst_add_zero", {31'd0, zero}, 32'd0);
    chk("post_rst_add_lat", lat, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
